// File: rtl/gmsk_tx_pkg.sv
// Shared definitions for the GMSK burst sequencer.
// Holds the sequencer state enumeration, the default parameter values used
// by the top level, and a helper that sizes the symbol counter.
package gmsk_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PRIME   = 3'd1,
    ST_ARMED   = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_TAIL    = 3'd4
  } state_t;

  localparam int DEF_IQ_BITS           = 8;
  localparam int DEF_CLOCKS_PER_SAMPLE = 5;
  localparam int DEF_PRIMING_SYMBOLS   = 4;
  localparam int DEF_TAIL_SYMBOLS      = 3;
  localparam int DEF_LEN_BITS          = 8;

  // Width needed to hold the largest count any state can reach:
  // max(2^len_bits-1, prime, tail).
  function automatic int count_width(input int len_bits, input int prime, input int tail);
    int m;
    m = (1 << len_bits) - 1;
    if (prime > m) begin
      m = prime;
    end else begin
      m = m;
    end
    if (tail > m) begin
      m = tail;
    end else begin
      m = m;
    end
    if (m < 1) begin
      return 1;
    end else begin
      return $clog2(m + 1);
    end
  endfunction

endpackage

// File: rtl/sample_strobe_gen.sv
// Free-running sample clock divider.
// Ports:
//   clock         in   rising-edge clock
//   reset         in   synchronous active-high reset
//   sample_strobe out  one-clock pulse every CLOCKS_PER_SAMPLE clocks
//                      (high while the counter is 0 and reset is low)
module sample_strobe_gen #(
  parameter int CLOCKS_PER_SAMPLE = 5
) (
  input  logic clock,
  input  logic reset,
  output logic sample_strobe
);

  localparam int CW = $clog2(CLOCKS_PER_SAMPLE);
  localparam logic [CW-1:0] LAST = CW'(CLOCKS_PER_SAMPLE - 1);

  logic [CW-1:0] count;

  // Divider counter: 0 .. CLOCKS_PER_SAMPLE-1, then wrap.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign sample_strobe = (count == '0) && !reset;

endmodule

// File: rtl/gmsk_burst_sequencer.sv
// GMSK burst sequencer.
// Feeds the modulator a priming run of 1-symbols, waits armed for a burst
// request, then streams the payload bits followed by a tail of 0-symbols,
// and forwards modulator I/Q samples to the RF chain while a burst is on air.
// Ports:
//   clock, reset                    clock and synchronous active-high reset
//   next_symbol_strobe              rising edge marks a symbol edge
//   current_symbol                  symbol presented to the modulator
//   sample_strobe                   one pulse every CLOCKS_PER_SAMPLE clocks
//   fire_burst, burst_len           burst request and payload length
//   payload_bit, payload_ready      payload data and its consume strobe
//   is_armed, burst_done            primed indication, end-of-tail pulse
//   modulator_inphase/quadrature    modulator samples in
//   rfchain_inphase/quadrature      registered samples out, iq_valid qualifies
module gmsk_burst_sequencer
  import gmsk_tx_pkg::*;
#(
  parameter int IQ_BITS           = DEF_IQ_BITS,
  parameter int CLOCKS_PER_SAMPLE = DEF_CLOCKS_PER_SAMPLE,
  parameter int PRIMING_SYMBOLS   = DEF_PRIMING_SYMBOLS,
  parameter int TAIL_SYMBOLS      = DEF_TAIL_SYMBOLS,
  parameter int LEN_BITS          = DEF_LEN_BITS
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               next_symbol_strobe,
  output logic               current_symbol,
  output logic               sample_strobe,
  input  logic               fire_burst,
  input  logic [LEN_BITS-1:0] burst_len,
  input  logic               payload_bit,
  output logic               payload_ready,
  output logic               is_armed,
  output logic               burst_done,
  input  logic [IQ_BITS-1:0] modulator_inphase,
  input  logic [IQ_BITS-1:0] modulator_quadrature,
  output logic [IQ_BITS-1:0] rfchain_inphase,
  output logic [IQ_BITS-1:0] rfchain_quadrature,
  output logic               iq_valid
);

  localparam int CNT_W = count_width(LEN_BITS, PRIMING_SYMBOLS, TAIL_SYMBOLS);
  localparam logic [CNT_W-1:0] PRIME_LAST = CNT_W'(PRIMING_SYMBOLS - 1);
  localparam logic [CNT_W-1:0] TAIL_LAST  = CNT_W'(TAIL_SYMBOLS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  state_t              state;
  state_t              state_next;
  logic                strobe_prev;
  logic                sym_edge;
  logic [CNT_W-1:0]    sym_count;
  logic [LEN_BITS-1:0] len_latched;
  logic [CNT_W-1:0]    len_last;
  logic                count_clear;
  logic                count_step;
  logic                sym_load;
  logic                sym_value;
  logic                len_capture;
  logic                done_next;

  sample_strobe_gen #(
    .CLOCKS_PER_SAMPLE(CLOCKS_PER_SAMPLE)
  ) u_sample_strobe_gen (
    .clock         (clock),
    .reset         (reset),
    .sample_strobe (sample_strobe)
  );

  // One edge per high period of the strobe, however long it stays high.
  assign sym_edge = next_symbol_strobe & ~strobe_prev;
  // Only meaningful in PAYLOAD, where len_latched is known to be nonzero.
  assign len_last = CNT_W'(len_latched) - CNT_W'(1);

  // Next-state and control decode.
  always_comb begin
    state_next    = state;
    count_clear   = 1'b0;
    count_step    = 1'b0;
    sym_load      = 1'b0;
    sym_value     = 1'b1;
    len_capture   = 1'b0;
    done_next     = 1'b0;
    payload_ready = 1'b0;
    is_armed      = 1'b0;
    case (state)
      ST_IDLE: begin
        state_next  = ST_PRIME;
        count_clear = 1'b1;
      end
      ST_PRIME: begin
        if (sym_edge) begin
          sym_load  = 1'b1;
          sym_value = 1'b1;
          if (sym_count == PRIME_LAST) begin
            state_next  = ST_ARMED;
            count_clear = 1'b1;
          end else begin
            count_step = 1'b1;
          end
        end else begin
          count_step = 1'b0;
        end
      end
      ST_ARMED: begin
        is_armed = 1'b1;
        if (fire_burst) begin
          len_capture = 1'b1;
          count_clear = 1'b1;
          // A zero-length burst skips PAYLOAD and goes straight to the tail.
          if (burst_len == '0) begin
            state_next = ST_TAIL;
          end else begin
            state_next = ST_PAYLOAD;
          end
        end else begin
          state_next = ST_ARMED;
        end
      end
      ST_PAYLOAD: begin
        if (sym_edge) begin
          payload_ready = 1'b1;
          sym_load      = 1'b1;
          sym_value     = payload_bit;
          if (sym_count == len_last) begin
            state_next  = ST_TAIL;
            count_clear = 1'b1;
          end else begin
            count_step = 1'b1;
          end
        end else begin
          count_step = 1'b0;
        end
      end
      ST_TAIL: begin
        if (sym_edge) begin
          sym_load  = 1'b1;
          sym_value = 1'b0;
          if (sym_count == TAIL_LAST) begin
            state_next  = ST_PRIME;
            count_clear = 1'b1;
            done_next   = 1'b1;
          end else begin
            count_step = 1'b1;
          end
        end else begin
          count_step = 1'b0;
        end
      end
      default: begin
        state_next  = ST_IDLE;
        count_clear = 1'b1;
      end
    endcase
    // Reset must never look like a consumed payload bit or an armed sequencer.
    if (reset) begin
      payload_ready = 1'b0;
      is_armed      = 1'b0;
    end else begin
      payload_ready = payload_ready;
    end
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Edge history, symbol counter, latched length, symbol and done pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      strobe_prev    <= 1'b0;
      sym_count      <= '0;
      len_latched    <= '0;
      current_symbol <= 1'b1;
      burst_done     <= 1'b0;
    end else begin
      strobe_prev <= next_symbol_strobe;
      burst_done  <= done_next;
      // Counter saturates rather than wrapping.
      if (count_clear) begin
        sym_count <= '0;
      end else if (count_step && (sym_count != CNT_MAX)) begin
        sym_count <= sym_count + CNT_W'(1);
      end else begin
        sym_count <= sym_count;
      end
      if (len_capture) begin
        len_latched <= burst_len;
      end else begin
        len_latched <= len_latched;
      end
      // The symbol only changes on an edge, so the last tail zero is held
      // for a full symbol interval before priming 1s resume.
      if (sym_load) begin
        current_symbol <= sym_value;
      end else begin
        current_symbol <= current_symbol;
      end
    end
  end

  // RF chain sample register: pass-through while a burst is on air.
  always_ff @(posedge clock) begin
    if (reset) begin
      rfchain_inphase    <= '0;
      rfchain_quadrature <= '0;
      iq_valid           <= 1'b0;
    end else if ((state == ST_PAYLOAD) || (state == ST_TAIL)) begin
      rfchain_inphase    <= modulator_inphase;
      rfchain_quadrature <= modulator_quadrature;
      iq_valid           <= 1'b1;
    end else begin
      rfchain_inphase    <= '0;
      rfchain_quadrature <= '0;
      iq_valid           <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gmsk_burst_sequencer.sv
// Self-checking bench for gmsk_burst_sequencer. Two instances share all
// inputs: dut_a with CLOCKS_PER_SAMPLE=5 and dut_b with CLOCKS_PER_SAMPLE=3.
// Each generated symbol edge pushes its expected payload_ready and resulting
// current_symbol to a queue; a negedge monitor pops and compares.
module tb_gmsk_burst_sequencer;

  localparam int IQ = 8;

  typedef struct {
    logic ready;
    logic sym;
  } rec_t;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          strobe = 1'b0;
  logic          fire = 1'b0;
  logic          pbit = 1'b0;
  logic [7:0]    blen = 8'd0;
  logic [IQ-1:0] mod_i = '0;
  logic [IQ-1:0] mod_q = '0;

  logic          a_sym, a_ss, a_pr, a_arm, a_done, a_iqv;
  logic [IQ-1:0] a_ri, a_rq;
  logic          b_sym, b_ss, b_pr, b_arm, b_done, b_iqv;
  logic [IQ-1:0] b_ri, b_rq;

  int   n_tests = 0;
  int   n_fail = 0;
  rec_t exp_q[$];
  rec_t cur;
  logic hist = 1'b0;
  logic pend = 1'b0;
  int   cyc = 0;
  int   ss_a_last = -1;
  int   ss_b_last = -1;
  int   pr_a = 0, pr_b = 0, done_a = 0, done_b = 0;
  logic [IQ-1:0] mi_prev = '0;
  logic [IQ-1:0] mq_prev = '0;

  always #5 clock = ~clock;

  gmsk_burst_sequencer #(.CLOCKS_PER_SAMPLE(5)) dut_a (
    .clock(clock), .reset(reset), .next_symbol_strobe(strobe),
    .current_symbol(a_sym), .sample_strobe(a_ss), .fire_burst(fire),
    .burst_len(blen), .payload_bit(pbit), .payload_ready(a_pr),
    .is_armed(a_arm), .burst_done(a_done),
    .modulator_inphase(mod_i), .modulator_quadrature(mod_q),
    .rfchain_inphase(a_ri), .rfchain_quadrature(a_rq), .iq_valid(a_iqv)
  );

  gmsk_burst_sequencer #(.CLOCKS_PER_SAMPLE(3)) dut_b (
    .clock(clock), .reset(reset), .next_symbol_strobe(strobe),
    .current_symbol(b_sym), .sample_strobe(b_ss), .fire_burst(fire),
    .burst_len(blen), .payload_bit(pbit), .payload_ready(b_pr),
    .is_armed(b_arm), .burst_done(b_done),
    .modulator_inphase(mod_i), .modulator_quadrature(mod_q),
    .rfchain_inphase(b_ri), .rfchain_quadrature(b_rq), .iq_valid(b_iqv)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    mod_i = IQ'($urandom);
    mod_q = IQ'($urandom);
  endtask

  task automatic sym_edge(input int hi, input int lo, input logic er, input logic es);
    rec_t r;
    r.ready = er;
    r.sym   = es;
    exp_q.push_back(r);
    strobe = 1'b1;
    repeat (hi) tick();
    strobe = 1'b0;
    repeat (lo) tick();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_sym"},  {31'd0, a_sym} | ({31'd0, b_sym} << 1), 32'd3);
    check({tag, "_ss"},   {30'd0, a_ss, b_ss}, 32'd0);
    check({tag, "_pr"},   {30'd0, a_pr, b_pr}, 32'd0);
    check({tag, "_arm"},  {30'd0, a_arm, b_arm}, 32'd0);
    check({tag, "_done"}, {30'd0, a_done, b_done}, 32'd0);
    check({tag, "_iqv"},  {30'd0, a_iqv, b_iqv}, 32'd0);
    check({tag, "_rf"},   {a_ri, a_rq, b_ri, b_rq}, 32'd0);
  endtask

  task automatic check_arm(input string tag, input logic exp);
    check({tag, "_a"}, {31'd0, a_arm}, {31'd0, exp});
    check({tag, "_b"}, {31'd0, b_arm}, {31'd0, exp});
  endtask

  // Monitor: scoreboard pops, I/Q pass-through, strobe period, pulse counts.
  always @(negedge clock) begin
    cyc++;
    if (a_iqv) begin
      check("rf_a", {16'd0, a_ri, a_rq}, {16'd0, mi_prev, mq_prev});
    end else begin
      check("rf_a_zero", {16'd0, a_ri, a_rq}, 32'd0);
    end
    if (b_iqv) begin
      check("rf_b", {16'd0, b_ri, b_rq}, {16'd0, mi_prev, mq_prev});
    end else begin
      check("rf_b_zero", {16'd0, b_ri, b_rq}, 32'd0);
    end
    mi_prev = mod_i;
    mq_prev = mod_q;
    if (a_pr) pr_a++;
    if (b_pr) pr_b++;
    if (a_done) done_a++;
    if (b_done) done_b++;
    if (reset) begin
      check("rst_quiet", {28'd0, a_pr, a_done, b_pr, b_done}, 32'd0);
      hist = 1'b0;
      pend = 1'b0;
      ss_a_last = -1;
      ss_b_last = -1;
    end else begin
      if (a_ss) begin
        if (ss_a_last >= 0) check("ss_period_5", cyc - ss_a_last, 32'd5);
        ss_a_last = cyc;
      end
      if (b_ss) begin
        if (ss_b_last >= 0) check("ss_period_3", cyc - ss_b_last, 32'd3);
        ss_b_last = cyc;
      end
      if (pend) begin
        check("sym_a", {31'd0, a_sym}, {31'd0, cur.sym});
        check("sym_b", {31'd0, b_sym}, {31'd0, cur.sym});
        pend = 1'b0;
      end
      if (strobe && !hist) begin
        if (exp_q.size() > 0) begin
          cur = exp_q.pop_front();
          check("ready_a", {31'd0, a_pr}, {31'd0, cur.ready});
          check("ready_b", {31'd0, b_pr}, {31'd0, cur.ready});
          pend = 1'b1;
        end else begin
          check("sb_underflow", exp_q.size(), 32'd1);
        end
      end else begin
        check("ready_idle", {30'd0, a_pr, b_pr}, 32'd0);
      end
      hist = strobe;
    end
  end

  initial begin
    logic [4:0] bits;
    bits = 5'b01101;  // bit i is the i-th payload symbol: 1,0,1,1,0

    // Reset state
    repeat (3) tick();
    check_reset_vals("reset");
    reset = 1'b0;
    repeat (2) tick();

    // Priming, one edge held high for 7 clocks
    sym_edge(2, 18, 1'b0, 1'b1);
    check_arm("prime1_arm", 1'b0);
    check("prime_iqv", {30'd0, a_iqv, b_iqv}, 32'd0);
    sym_edge(7, 13, 1'b0, 1'b1);
    check_arm("prime2_arm", 1'b0);
    sym_edge(2, 18, 1'b0, 1'b1);
    check_arm("prime3_arm", 1'b0);
    sym_edge(2, 18, 1'b0, 1'b1);
    check_arm("prime4_arm", 1'b1);
    check("armed_iqv", {30'd0, a_iqv, b_iqv}, 32'd0);

    // Burst of 5, fire held high through the payload
    blen = 8'd5;
    fire = 1'b1;
    tick();
    blen = 8'd200;
    check_arm("fire_arm_drop", 1'b0);
    tick();
    check("payload_iqv", {30'd0, a_iqv, b_iqv}, 32'd3);
    for (int i = 0; i < 5; i++) begin
      pbit = bits[i];
      sym_edge(2, 18, 1'b1, bits[i]);
    end
    fire = 1'b0;
    for (int i = 0; i < 3; i++) sym_edge(2, 18, 1'b0, 1'b0);
    check("b1_pr_a", pr_a, 32'd5);
    check("b1_pr_b", pr_b, 32'd5);
    check("b1_done_a", done_a, 32'd1);
    check("b1_done_b", done_b, 32'd1);
    check("b1_iqv_off", {30'd0, a_iqv, b_iqv}, 32'd0);

    // Re-prime with fire pulses that must be ignored
    for (int i = 0; i < 4; i++) begin
      fire = 1'b1;
      tick();
      fire = 1'b0;
      sym_edge(2, 18, 1'b0, 1'b1);
      if (i == 2) check_arm("reprime3_arm", 1'b0);
    end
    check_arm("reprime4_arm", 1'b1);
    check("no_queued_fire_pr", pr_a, 32'd5);

    // Zero-length burst
    blen = 8'd0;
    fire = 1'b1;
    tick();
    fire = 1'b0;
    check_arm("z_arm_drop", 1'b0);
    tick();
    check("z_tail_iqv", {30'd0, a_iqv, b_iqv}, 32'd3);
    for (int i = 0; i < 3; i++) sym_edge(2, 18, 1'b0, 1'b0);
    check("z_pr_a", pr_a, 32'd5);
    check("z_done_a", done_a, 32'd2);
    check("z_done_b", done_b, 32'd2);
    for (int i = 0; i < 4; i++) sym_edge(2, 18, 1'b0, 1'b1);
    check_arm("z_rearm", 1'b1);

    // Reset at the second payload edge
    blen = 8'd4;
    fire = 1'b1;
    tick();
    fire = 1'b0;
    pbit = 1'b1;
    sym_edge(2, 18, 1'b1, 1'b1);
    pbit = 1'b0;
    reset = 1'b1;
    strobe = 1'b1;
    tick();
    check_reset_vals("midrst");
    strobe = 1'b0;
    reset = 1'b0;
    repeat (2) tick();
    for (int i = 0; i < 4; i++) begin
      sym_edge(2, 18, 1'b0, 1'b1);
      if (i == 2) check_arm("rst_prime3_arm", 1'b0);
    end
    check_arm("rst_rearm", 1'b1);
    check("rst_pr_a", pr_a, 32'd6);
    check("rst_done_a", done_a, 32'd2);
    check("sb_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gmsk_burst_sequencer.md
GMSK_BURST_SEQUENCER -- requirements
Module: gmsk_burst_sequencer

Interface
REQ-001 SHALL provide parameter IQ_BITS, default 8, I/Q sample width (sign included).
REQ-002 SHALL provide parameter CLOCKS_PER_SAMPLE, default 5, clocks per sample interval; minimum 2.
REQ-003 SHALL provide parameter PRIMING_SYMBOLS, default 4, symbols of constant 1 fed before arming.
REQ-004 SHALL provide parameter TAIL_SYMBOLS, default 3, symbols of constant 0 appended after payload.
REQ-005 SHALL provide parameter LEN_BITS, default 8, width of burst_len.
REQ-006 SHALL have one clock and a synchronous, active-high reset: clock  in  1  rising-edge clock.
REQ-007 reset  in  1  synchronous active-high reset.
REQ-008 next_symbol_strobe  in  1  modulator symbol-interval indication; its rising edge is a symbol edge.
REQ-009 current_symbol  out  1  symbol presented to the modulator.
REQ-010 sample_strobe  out  1  one-clock pulse every CLOCKS_PER_SAMPLE clocks.
REQ-011 fire_burst  in  1  start request; honoured only while is_armed=1.
REQ-012 burst_len  in  LEN_BITS  payload symbol count, sampled with fire_burst.
REQ-013 payload_bit  in  1  next payload symbol.
REQ-014 payload_ready  out  1  high exactly in the cycle payload_bit is consumed.
REQ-015 is_armed  out  1  sequencer is primed and accepts fire_burst.
REQ-016 burst_done  out  1  one-clock pulse when the tail completes.
REQ-017 modulator_inphase, modulator_quadrature  in  IQ_BITS each  modulator samples.
REQ-018 rfchain_inphase, rfchain_quadrature  out  IQ_BITS each  registered samples to the RF chain.
REQ-019 iq_valid  out  1  rfchain samples are valid.

Function
REQ-020 Symbol edge SHALL be the cycle in which next_symbol_strobe=1 and its registered previous value=0; exactly one edge per high period, however long.
REQ-021 States SHALL be IDLE, PRIME, ARMED, PAYLOAD, TAIL; IDLE goes to PRIME on the first cycle after reset is released.
REQ-022 PRIME: current_symbol=1; symbol counter counts edges; after PRIMING_SYMBOLS edges -> ARMED.
REQ-023 ARMED: is_armed=1, current_symbol=1; fire_burst=1 latches burst_len -> PAYLOAD next cycle, is_armed falls in the same cycle.
REQ-024 PAYLOAD: on each edge, payload_ready=1 combinationally, current_symbol<=payload_bit; after burst_len edges -> TAIL.
REQ-025 burst_len=0 SHALL go ARMED -> TAIL directly, with no payload_ready pulse.
REQ-026 TAIL: on each edge current_symbol<=0; after TAIL_SYMBOLS edges -> PRIME with burst_done=1 for that one cycle.
REQ-027 fire_burst outside ARMED SHALL be ignored and not queued; burst_len changes outside the fire cycle have no effect.
REQ-028 Clock divider counter SHALL count 0..CLOCKS_PER_SAMPLE-1 and wrap; sample_strobe=1 when counter=0 and reset=0; it runs in all states.
REQ-029 rfchain_* and iq_valid SHALL be registered with 1-clock latency; while state is PAYLOAD or TAIL they copy modulator_*, and iq_valid=1.
REQ-030 In all other states, rfchain_*=0 and iq_valid=0.
REQ-031 The symbol counter SHALL be wide enough for max(2^LEN_BITS-1, PRIMING_SYMBOLS, TAIL_SYMBOLS), clear on each state entry and never wrap.

Reset
REQ-032 reset SHALL override all activity, including mid-burst, returning to IDLE in the next cycle.
REQ-033 Reset values: current_symbol=1, sample_strobe=0, payload_ready=0, is_armed=0, burst_done=0, rfchain_*=0, iq_valid=0, divider counter=0, edge history=0.
REQ-034 Reset SHALL NOT generate burst_done or payload_ready.

Structure
REQ-035 Package gmsk_tx_pkg SHALL hold the state enumeration and the default parameter constants.
REQ-036 The clock divider SHALL be a sub-module sample_strobe_gen, parameterised by CLOCKS_PER_SAMPLE.

Verification
REQ-037 Strobe every 20 clocks, defaults -> is_armed rises after the 4th edge; iq_valid=0 and current_symbol=1 throughout.
REQ-038 Armed, fire_burst with burst_len=5, payload 1,0,1,1,0 -> 5 payload_ready pulses, current_symbol follows the bits, then 3 zeros, then burst_done once; is_armed returns after 4 more edges.
REQ-039 burst_len=0 fire -> 0 payload_ready pulses, 3 tail symbols, burst_done.
REQ-040 fire_burst held high during PAYLOAD and pulsed during PRIME -> no second burst and no state change.
REQ-041 reset asserted at the 2nd payload edge -> all outputs at reset values next cycle, re-priming begins.
REQ-042 CLOCKS_PER_SAMPLE=3 and 5 -> sample_strobe period exactly 3 and 5 clocks; strobe held high for 7 clocks counts as one edge.
